// File: rtl/ysyx_arb_pkg.sv
// ysyx_arb_pkg: shared state and owner encodings for the memory arbiter
package ysyx_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;
endpackage

// File: rtl/ysyx_mem_arbiter_if.sv
// ysyx_mem_arbiter_if: IFU, LSU and memory handshake bundle around the arbiter
interface ysyx_mem_arbiter_if #(parameter int WIDTH = 32);
    logic             ifu_req_valid;
    logic             ifu_req_ready;
    logic [WIDTH-1:0] ifu_addr;
    logic             ifu_rsp_valid;
    logic [WIDTH-1:0] ifu_rsp_data;
    logic             ifu_rsp_err;
    logic             lsu_req_valid;
    logic             lsu_req_ready;
    logic [WIDTH-1:0] lsu_addr;
    logic             lsu_we;
    logic [WIDTH-1:0] lsu_wdata;
    logic [WIDTH/8-1:0] lsu_wmask;
    logic             lsu_rsp_valid;
    logic [WIDTH-1:0] lsu_rsp_data;
    logic             lsu_rsp_err;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH/8-1:0] mem_wmask;
    logic             mem_rsp_valid;
    logic             mem_rsp_ready;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_err;
    // arbiter side: accepts requester traffic and drives the memory port
    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
        output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rdata, mem_err
    );
    // environment side: requesters and memory model
    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rdata, mem_err
    );
endinterface

// File: rtl/ysyx_rr_arb2.sv
// ysyx_rr_arb2: combinational two-way round-robin picker favouring the requester not granted last
module ysyx_rr_arb2
    import ysyx_arb_pkg::*;
(
    input  logic       valid_ifu,
    input  logic       valid_lsu,
    input  owner_t     last_grant,
    output logic [1:0] gnt,
    output logic       gnt_valid
);
    // bit 0 = IFU, bit 1 = LSU; a tie goes to whoever did not win last time
    always_comb begin
        gnt[0]    = valid_ifu && (!valid_lsu || last_grant == OWN_LSU);
        gnt[1]    = valid_lsu && (!valid_ifu || last_grant == OWN_IFU);
        gnt_valid = valid_ifu || valid_lsu;
    end
endmodule

// File: rtl/ysyx_mem_arbiter.sv
// ysyx_mem_arbiter: shares one memory port between IFU and LSU, one transaction at a time, with watchdog
module ysyx_mem_arbiter
    import ysyx_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic rst,
    ysyx_mem_arbiter_if.master bus
);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t             state, state_d;
    owner_t             owner, last_grant, pick;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   addr, wdata, rdata;
    logic [WIDTH/8-1:0] wmask;
    logic               we, err;
    logic [1:0]         gnt;
    logic               gnt_valid, grant, busy, req_hs, rsp_hs, tmo, rsp_ifu, rsp_lsu;

    ysyx_rr_arb2 u_rr (
        .valid_ifu  (bus.ifu_req_valid),
        .valid_lsu  (bus.lsu_req_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid)
    );

    // next-state decode; a mem handshake takes priority over a same-cycle timeout
    always_comb begin
        pick    = gnt[1] ? OWN_LSU : OWN_IFU;
        busy    = state == REQ || state == WAIT;
        grant   = state == IDLE && gnt_valid;
        req_hs  = state == REQ && bus.mem_req_ready;
        rsp_hs  = state == WAIT && bus.mem_rsp_valid;
        tmo     = busy && TIMEOUT != 0 && cnt >= T_LAST && !req_hs && !rsp_hs;
        state_d = grant ? REQ : (rsp_hs || tmo) ? RESP : req_hs ? WAIT : state == RESP ? IDLE : state;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // request latch on grant, response latch on completion or timeout, watchdog count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWN_IFU;
            last_grant <= OWN_LSU;
            cnt        <= '0;
            addr       <= '0;
            we         <= 1'b0;
            wdata      <= '0;
            wmask      <= '0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            if (grant) begin
                owner      <= pick;
                last_grant <= pick;
                cnt        <= '0;
                addr       <= gnt[1] ? bus.lsu_addr : bus.ifu_addr;
                we         <= gnt[1] && bus.lsu_we;
                wdata      <= gnt[1] ? bus.lsu_wdata : '0;
                wmask      <= gnt[1] ? bus.lsu_wmask : '0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
            if (rsp_hs) begin
                rdata <= bus.mem_rdata;
                err   <= bus.mem_err;
            end else if (tmo) begin
                rdata <= '0;
                err   <= 1'b1;
            end
        end
    end

    assign rsp_ifu           = state == RESP && owner == OWN_IFU;
    assign rsp_lsu           = state == RESP && owner == OWN_LSU;
    assign bus.ifu_req_ready = rst && grant && pick == OWN_IFU;
    assign bus.lsu_req_ready = rst && grant && pick == OWN_LSU;
    assign bus.ifu_rsp_valid = rsp_ifu;
    assign bus.ifu_rsp_data  = rsp_ifu ? rdata : '0;
    assign bus.ifu_rsp_err   = rsp_ifu && err;
    assign bus.lsu_rsp_valid = rsp_lsu;
    assign bus.lsu_rsp_data  = rsp_lsu ? rdata : '0;
    assign bus.lsu_rsp_err   = rsp_lsu && err;
    assign bus.mem_req_valid = state == REQ;
    assign bus.mem_rsp_ready = state == WAIT;
    assign bus.mem_addr      = addr;
    assign bus.mem_we        = we;
    assign bus.mem_wdata     = wdata;
    assign bus.mem_wmask     = wmask;
endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb_ysyx_mem_arbiter: directed self-checking bench for the IFU/LSU memory arbiter
module tb_ysyx_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;

    ysyx_mem_arbiter_if #(.WIDTH(32)) bus ();

    ysyx_mem_arbiter #(.WIDTH(32), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid = 0; bus.ifu_addr = 0;
        bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_we = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rdata = 0; bus.mem_err = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_inputs();
        repeat (2) tick();
        rst = 1;
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1; bus.mem_req_ready = 1; bus.mem_rsp_valid = 1;
        bus.mem_rdata = 32'hFFFF_FFFF; bus.mem_err = 1;
        tick();
        checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.mem_rsp_ready} !== 4'b0) begin fails++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.mem_rsp_ready}); end
        checks++; if ({bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.mem_we, bus.mem_wmask} !== 8'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0", {bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.mem_we, bus.mem_wmask}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.ifu_rsp_data, bus.lsu_rsp_data} !== 128'b0) begin fails++; $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.ifu_rsp_data, bus.lsu_rsp_data}); end
    endtask

    task automatic test_ifu_fetch();
        do_reset();
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0000;
        #1;
        checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin fails++; $display("FAIL fetch_grant: got %b expected 10", {bus.ifu_req_ready, bus.lsu_req_ready}); end
        tick();
        bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
        #1;
        checks++; if ({bus.mem_req_valid, bus.mem_rsp_ready, bus.mem_we, bus.mem_wmask} !== 7'b1000000) begin fails++; $display("FAIL fetch_req: got %b expected 1000000", {bus.mem_req_valid, bus.mem_rsp_ready, bus.mem_we, bus.mem_wmask}); end
        checks++; if (bus.mem_addr !== 32'h8000_0000) begin fails++; $display("FAIL fetch_addr: got %h expected 80000000", bus.mem_addr); end
        tick();
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 1; bus.mem_rdata = 32'h0000_0413; bus.mem_err = 0;
        #1;
        checks++; if ({bus.mem_req_valid, bus.mem_rsp_ready} !== 2'b01) begin fails++; $display("FAIL fetch_wait: got %b expected 01", {bus.mem_req_valid, bus.mem_rsp_ready}); end
        tick();
        bus.mem_rsp_valid = 0;
        checks++; if ({bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rsp_valid} !== 3'b100) begin fails++; $display("FAIL fetch_rsp: got %b expected 100", {bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rsp_valid}); end
        checks++; if (bus.ifu_rsp_data !== 32'h0000_0413) begin fails++; $display("FAIL fetch_data: got %h expected 00000413", bus.ifu_rsp_data); end
        tick();
        checks++; if (bus.ifu_rsp_valid !== 1'b0) begin fails++; $display("FAIL fetch_pulse: got %b expected 0", bus.ifu_rsp_valid); end
    endtask

    task automatic test_round_robin();
        int   g;
        logic exp_lsu;
        logic [31:0] exp_data;
        do_reset();
        g = 0;
        bus.ifu_addr = 32'h100; bus.lsu_addr = 32'h200;
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            exp_lsu = (i % 2) == 1;
            exp_data = 32'hA0 + 32'(i);
            #1;
            checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin fails++; $display("FAIL rr_grant%0d: got %b expected %b", i, {bus.ifu_req_ready, bus.lsu_req_ready}, {!exp_lsu, exp_lsu}); end
            if (i > 0) begin
                checks++; if (cyc - g !== 4) begin fails++; $display("FAIL rr_spacing%0d: got %0d expected 4", i, cyc - g); end
            end
            g = cyc;
            tick();
            checks++; if (bus.mem_addr !== (exp_lsu ? 32'h200 : 32'h100)) begin fails++; $display("FAIL rr_addr%0d: got %h", i, bus.mem_addr); end
            bus.mem_req_ready = 1;
            tick();
            bus.mem_req_ready = 0; bus.mem_rsp_valid = 1; bus.mem_rdata = exp_data;
            tick();
            bus.mem_rsp_valid = 0;
            #1;
            checks++; if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_req_ready, bus.lsu_req_ready} !== {!exp_lsu, exp_lsu, 2'b00}) begin fails++; $display("FAIL rr_rsp%0d: got %b expected %b", i, {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_req_ready, bus.lsu_req_ready}, {!exp_lsu, exp_lsu, 2'b00}); end
            checks++; if ((exp_lsu ? bus.lsu_rsp_data : bus.ifu_rsp_data) !== exp_data || (exp_lsu ? bus.ifu_rsp_data : bus.lsu_rsp_data) !== 32'h0) begin fails++; $display("FAIL rr_data%0d: got ifu %h lsu %h expected owner %h", i, bus.ifu_rsp_data, bus.lsu_rsp_data, exp_data); end
            @(posedge clk);
        end
        bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_store_stall();
        do_reset();
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_1000; bus.lsu_we = 1;
        bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'b0011;
        #1;
        checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin fails++; $display("FAIL store_grant: got %b expected 01", {bus.ifu_req_ready, bus.lsu_req_ready}); end
        tick();
        bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0; bus.lsu_we = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_req_ready = (i == 3);
            #1;
            checks++; if ({bus.mem_req_valid, bus.mem_we, bus.mem_wmask, bus.mem_addr, bus.mem_wdata} !== {2'b11, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF}) begin fails++; $display("FAIL store_hold%0d: got %b %b %b %h %h", i, bus.mem_req_valid, bus.mem_we, bus.mem_wmask, bus.mem_addr, bus.mem_wdata); end
            tick();
        end
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 1; bus.mem_rdata = 32'h0;
        tick();
        bus.mem_rsp_valid = 0;
        checks++; if ({bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.ifu_rsp_valid} !== 3'b100) begin fails++; $display("FAIL store_rsp: got %b expected 100", {bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.ifu_rsp_valid}); end
        tick();
        checks++; if (bus.lsu_rsp_valid !== 1'b0) begin fails++; $display("FAIL store_pulse: got %b expected 0", bus.lsu_rsp_valid); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_2000;
        tick();
        bus.lsu_req_valid = 0;
        n = 0;
        while (bus.mem_req_valid === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++; if (n !== 16) begin fails++; $display("FAIL tmo_len: got %0d expected 16", n); end
        checks++; if ({bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.ifu_rsp_valid} !== 3'b110 || bus.lsu_rsp_data !== 32'h0) begin fails++; $display("FAIL tmo_rsp: got %b data %h expected 110 data 0", {bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.ifu_rsp_valid}, bus.lsu_rsp_data); end
        tick();
        checks++; if ({bus.lsu_rsp_valid, bus.mem_req_valid, bus.mem_rsp_ready} !== 3'b000) begin fails++; $display("FAIL tmo_idle: got %b expected 000", {bus.lsu_rsp_valid, bus.mem_req_valid, bus.mem_rsp_ready}); end
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0004;
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b1) begin fails++; $display("FAIL tmo_next_grant: got %b expected 1", bus.ifu_req_ready); end
        tick();
        bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 1; bus.mem_rdata = 32'h0000_CAFE;
        tick();
        bus.mem_rsp_valid = 0;
        checks++; if ({bus.ifu_rsp_valid, bus.ifu_rsp_err} !== 2'b10 || bus.ifu_rsp_data !== 32'h0000_CAFE) begin fails++; $display("FAIL tmo_next_rsp: got %b data %h expected 10 data 0000cafe", {bus.ifu_rsp_valid, bus.ifu_rsp_err}, bus.ifu_rsp_data); end
    endtask

    task automatic test_bus_error();
        do_reset();
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0008;
        tick();
        bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 1; bus.mem_rdata = 32'h1234_5678; bus.mem_err = 1;
        tick();
        bus.mem_rsp_valid = 0; bus.mem_err = 0;
        checks++; if ({bus.ifu_rsp_valid, bus.ifu_rsp_err} !== 2'b11) begin fails++; $display("FAIL err_flag: got %b expected 11", {bus.ifu_rsp_valid, bus.ifu_rsp_err}); end
        checks++; if (bus.ifu_rsp_data !== 32'h1234_5678) begin fails++; $display("FAIL err_data: got %h expected 12345678", bus.ifu_rsp_data); end
    endtask

    task automatic test_reset_in_wait();
        int pulses;
        do_reset();
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_3000; bus.lsu_we = 1; bus.lsu_wdata = 32'h5555_AAAA; bus.lsu_wmask = 4'hF;
        tick();
        bus.lsu_req_valid = 0; bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0;
        checks++; if (bus.mem_rsp_ready !== 1'b1) begin fails++; $display("FAIL rw_in_wait: got %b expected 1", bus.mem_rsp_ready); end
        #2;
        rst = 0;
        #1;
        checks++; if ({bus.mem_rsp_ready, bus.mem_req_valid, bus.mem_we, bus.mem_wmask, bus.lsu_rsp_valid, bus.ifu_rsp_valid} !== 8'b0 || {bus.mem_addr, bus.mem_wdata} !== 64'h0) begin fails++; $display("FAIL rw_async: got %b %h %h expected 0", {bus.mem_rsp_ready, bus.mem_req_valid, bus.mem_we, bus.mem_wmask, bus.lsu_rsp_valid, bus.ifu_rsp_valid}, bus.mem_addr, bus.mem_wdata); end
        tick();
        rst = 1;
        bus.mem_rsp_valid = 1; bus.mem_rdata = 32'h7777_7777;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.ifu_rsp_valid === 1'b1 || bus.lsu_rsp_valid === 1'b1 || bus.mem_rsp_ready === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin fails++; $display("FAIL rw_late_rsp: got %0d expected 0", pulses); end
        bus.mem_rsp_valid = 0;
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1; bus.ifu_addr = 32'h10; bus.lsu_addr = 32'h20;
        #1;
        checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin fails++; $display("FAIL rw_first_grant: got %b expected 10", {bus.ifu_req_ready, bus.lsu_req_ready}); end
        tick();
        bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
        checks++; if (bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL rw_first_addr: got %h we %b expected 00000010 we 0", bus.mem_addr, bus.mem_we); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_ifu_fetch();
        test_round_robin();
        test_store_stall();
        test_timeout();
        test_bus_error();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ysyx_mem_arbiter.md
Name: ysyx_mem_arbiter

Overview:
- Shares one memory port between two requesters: the instruction fetch unit and the load/store unit.
- Sits between IFU/MEM and the memory model, so fetch and data access no longer need separate memories.
- Allows only one transaction in flight at a time.
- Uses round-robin arbitration and has a watchdog timeout that returns an error response.

Parameters:
- WIDTH, 32: address and data width.
- TIMEOUT, 256: cycles allowed in REQ+WAIT before an error response; 0 disables the watchdog.
- CNT_W, 16: watchdog counter width; TIMEOUT must be less than 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted
- ifu_addr  in  WIDTH  fetch address
- ifu_rsp_valid  out  1  fetch response pulse
- ifu_rsp_data  out  WIDTH  fetched instruction
- ifu_rsp_err  out  1  fetch error (bus error or timeout)
- lsu_req_valid  in  1  data request
- lsu_req_ready  out  1  data request accepted
- lsu_addr  in  WIDTH  data address
- lsu_we  in  1  1 = store
- lsu_wdata  in  WIDTH  store data
- lsu_wmask  in  WIDTH/8  byte strobes
- lsu_rsp_valid  out  1  data response pulse
- lsu_rsp_data  out  WIDTH  load data
- lsu_rsp_err  out  1  data error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  WIDTH  latched address
- mem_we  out  1  latched write enable
- mem_wdata  out  WIDTH  latched write data
- mem_wmask  out  WIDTH/8  latched strobes
- mem_rsp_valid  in  1  memory response
- mem_rsp_ready  out  1  arbiter accepts response
- mem_rdata  in  WIDTH  read data
- mem_err  in  1  bus error

Behaviour:
- The reset value of every output is 0.
- Internal reset values: state=IDLE, owner=IFU, last_grant=LSU (so the first contended grant goes to IFU), cnt=0.
- States are IDLE, REQ, WAIT and RESP.
- IDLE:
  - Arbitration is combinational.
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to last_grant is granted.
  - The granted requester sees *_req_ready=1 in that same cycle, and only then; at most one ready is high per cycle.
  - On grant: latch addr/we/wdata/wmask (IFU grant forces we=0 and wmask=0), set owner, set last_grant=owner, clear cnt, go to REQ.
- REQ:
  - mem_req_valid=1; fields are held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready, go to WAIT.
- WAIT:
  - mem_rsp_ready=1.
  - On mem_rsp_valid, latch rdata/err and go to RESP.
  - mem_rsp_valid is ignored in any other state.
- RESP:
  - For exactly one cycle, the owner's *_rsp_valid=1, with *_rsp_data/*_rsp_err from the latch.
  - The non-owner's rsp outputs stay 0.
  - Go to IDLE.
  - A new grant cannot occur in the RESP cycle, so back-to-back requests are at least 4 cycles apart.
- Watchdog (TIMEOUT>0):
  - cnt increments every REQ/WAIT cycle.
  - When cnt==TIMEOUT-1 and no completing handshake occurs that cycle, go to RESP with err=1 and data=0.
  - Mem handshakes win over a timeout occurring in the same cycle.
  - After a timeout abandoned in WAIT, a late mem_rsp_valid is never forwarded: IDLE/REQ keep mem_rsp_ready=0, and the bench memory must drop it.
- Requester rules:
  - Requesters hold valid and fields stable until ready.
  - A requester never withdraws an unaccepted request.
  - A requester always accepts a response; there is no rsp backpressure.
- Latency: with zero-wait memory, the grant occurs in cycle 0, mem_req_valid in cycle 1, mem_rsp_valid is accepted in cycle 2, and the rsp pulse occurs in cycle 3.
- Reset asserted in any state returns asynchronously to reset values, and any in-flight transaction is dropped without a response.
- mem_req_valid, mem_rsp_ready and *_rsp_valid are decoded from registered state only; there are no combinational paths from mem inputs to mem outputs.

Decomposition:
- Package ysyx_arb_pkg holds:
  - the state enum (IDLE/REQ/WAIT/RESP, 2 bits);
  - the owner encoding (OWN_IFU=0, OWN_LSU=1).
- One sub-module, ysyx_rr_arb2:
  - a combinational 2-way round-robin picker;
  - inputs: two valids and last_grant;
  - outputs: a grant one-hot and a grant-valid.
- The FSM, latches and watchdog stay in the top module.

Test Plan:
1. Reset, then IFU-only request to addr 0x80000000; zero-wait memory returns 0x00000413 in cycle 2 -> ifu_rsp_valid pulse in cycle 3 with data 0x00000413 and err 0; mem_we=0 and mem_wmask=0.
2. Both requesters held valid continuously -> grants alternate IFU, LSU, IFU, LSU; each rsp pulse reaches only the owner; a new grant occurs every 4 cycles.
3. LSU store to addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011; mem_req_ready low for 3 cycles -> mem fields are stable throughout, mem_we=1, and one lsu_rsp_valid pulse.
4. TIMEOUT=16 with mem_req_ready held 0 -> mem_req_valid is high for 16 cycles, then lsu_rsp_valid=1 with err=1 and data 0, then IDLE; a subsequent IFU request completes normally.
5. Memory returns mem_err=1 with rdata 0x12345678 -> ifu_rsp_err=1 and ifu_rsp_data=0x12345678.
6. rst driven low during WAIT, then released, and a late mem_rsp_valid arrives -> all outputs are 0 immediately, no rsp pulse occurs, and the next contended grant goes to IFU.
